vga_timing_sequencer: RTL and testbench
=======================================

Name: vga_timing_sequencer

Overview:
Generates the complete raster timing for the VGA controller: horizontal and vertical phase sequencing, sync pulses, display-enable and pixel coordinates. Replaces the free-running counter and threshold-detect pair with an explicit two-axis phase state machine. It sits between the pixel clock and the pixel generator / DAC output stage. Default timing is 1024x768 @ 70 Hz (75 MHz pixel clock; 1328 clocks per line, 806 lines per frame).

Parameters:
COUNTER_SIZE, 11, width of all position and phase counters
H_ACTIVE, 1024, visible pixels per line
H_FRONT, 24, horizontal front porch (clocks)
H_SYNC, 136, horizontal sync width (clocks)
H_BACK, 144, horizontal back porch (clocks)
V_ACTIVE, 768, visible lines per frame
V_FRONT, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BACK, 29, vertical back porch (lines)
SYNC_POLARITY, 1'b0, asserted level of hsync/vsync (0 = negative sync)

Ports:
control_clock  input  1  pixel clock
control_reset_n  input  1  asynchronous active-low reset
enable  input  1  advance timing; low freezes every counter, state and output
hsync  output  1  horizontal sync, asserted level SYNC_POLARITY
vsync  output  1  vertical sync, asserted level SYNC_POLARITY
display_enable  output  1  high when both axes are in ACTIVE
pixel_x  output  COUNTER_SIZE  horizontal position in line, 0..H_TOTAL-1
pixel_y  output  COUNTER_SIZE  line number in frame, 0..V_TOTAL-1
line_start  output  1  one-cycle pulse at pixel_x==0
frame_start  output  1  one-cycle pulse at pixel_x==0 and pixel_y==0

Behaviour:
- H_TOTAL = sum of H_* (1328); V_TOTAL = sum of V_* (806). Elaboration error if any phase length is 0 or either total exceeds 2^COUNTER_SIZE.
- Per axis FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Phase counter runs 0..len-1 and, on reaching len-1, moves to the next state and clears to 0. The position counter runs 0..TOTAL-1 and wraps to 0 on the BACK->ACTIVE transition.
- The horizontal axis advances on every clock with enable=1. The vertical axis advances only on the cycle the horizontal axis wraps (BACK, last count).
- Simultaneous horizontal and vertical wrap: both return to ACTIVE/0 on the same edge, giving pixel_x=0 and pixel_y=0.
- All outputs are registered and decoded from the counter/state values being loaded, so outputs describe the current position with no extra lag.
  - hsync = SYNC_POLARITY when the H state is SYNC, else the inverse; vsync likewise for the V state.
  - display_enable = (H==ACTIVE) and (V==ACTIVE).
  - pixel_x and pixel_y are always driven, including during blanking.
- Reset (asynchronous assert, synchronous-release usage assumed upstream):
  - Both FSMs in ACTIVE, all counters 0.
  - pixel_x=0, pixel_y=0, hsync=vsync=~SYNC_POLARITY.
  - display_enable=0, line_start=0, frame_start=0.
- First enabled edge after reset: outputs show position (0,0): display_enable=1, line_start=1, frame_start=1.
- enable=0: all registers hold, and pulse outputs are forced to 0 on the next edge, so a frozen cycle never repeats a pulse. On re-enable, sequencing resumes from the held position.
- Reset mid-line or mid-frame: immediate return to reset values, with no partial sync pulse held.
- Invariants: hsync pulse width exactly H_SYNC clocks; vsync width exactly V_SYNC*H_TOTAL clocks; vsync edges coincide with the horizontal wrap.

Decomposition:
- Package vga_timing_pkg:
  - phase enum (PHASE_ACTIVE, PHASE_FRONT, PHASE_SYNC, PHASE_BACK)
  - default 1024x768@70 timing constants
  - H_TOTAL/V_TOTAL helper functions
- Sub-module vga_axis_sequencer, instantiated twice:
  - Parameters: COUNTER_SIZE and the four phase lengths.
  - Ports: clock, reset, advance in; phase, position and wrap out.
  - The top level chains the horizontal wrap into the vertical advance and registers the decoded outputs.

Test Plan:
- Reset released, enable=1 -> first edge: pixel_x=0, pixel_y=0, display_enable=1, frame_start=1, hsync=vsync=1.
- Run one line -> display_enable high 1024 clocks; hsync low exactly at pixel_x 1048..1183 (136 clocks); pixel_x wraps 1327->0 with line_start=1.
- Run one frame -> vsync low for lines 771..776 (6*1328 clocks), with edges aligned to pixel_x=0; frame_start once per 1,070,368 clocks; pixel_y wraps 805->0.
- Drop enable for 50 cycles at pixel_x=500 -> all outputs hold, no pulses; on re-enable, the next pixel_x is 501.
- Assert control_reset_n low at pixel_x=1100 (inside hsync) -> hsync returns to 1 immediately, counters return to 0; restart matches scenario 1.
- Override to H 8/2/2/2 and V 4/1/1/1 with SYNC_POLARITY=1 -> pulse positions and widths scale correctly; sync is active-high.

Source files
------------

// File: rtl/vga_timing_sequencer_pkg.sv
// Shared types and default timing for the VGA raster sequencer.
// Default mode is 1024x768 @ 70 Hz on a 75 MHz pixel clock.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PHASE_ACTIVE = 2'd0,
        PHASE_FRONT  = 2'd1,
        PHASE_SYNC   = 2'd2,
        PHASE_BACK   = 2'd3
    } phase_e;

    localparam int DEF_COUNTER_SIZE = 11;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FRONT  = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BACK   = 144;

    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FRONT  = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BACK   = 29;

    // Clocks per line from the four horizontal phase lengths.
    function automatic int h_total(input int active, input int front,
                                   input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // Lines per frame from the four vertical phase lengths.
    function automatic int v_total(input int active, input int front,
                                   input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_sequencer_if.sv
// Raster timing bundle: the sequencer (master) consumes enable and
// produces the sync, blanking and coordinate signals.
interface vga_timing_sequencer_if
    import vga_timing_pkg::*;
#(
    parameter int COUNTER_SIZE = DEF_COUNTER_SIZE
);
    logic                    enable;
    logic                    hsync;
    logic                    vsync;
    logic                    display_enable;
    logic [COUNTER_SIZE-1:0] pixel_x;
    logic [COUNTER_SIZE-1:0] pixel_y;
    logic                    line_start;
    logic                    frame_start;

    modport master (
        input  enable,
        output hsync, vsync, display_enable, pixel_x, pixel_y,
               line_start, frame_start
    );

    modport slave (
        output enable,
        input  hsync, vsync, display_enable, pixel_x, pixel_y,
               line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_sequencer.sv
// One raster axis: ACTIVE -> FRONT -> SYNC -> BACK phase machine with a
// phase counter and a position counter. Outputs are the values being
// loaded on the coming edge, so the top can register decoded outputs
// that line up with the new position.
module vga_axis_sequencer
    import vga_timing_pkg::*;
#(
    parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
    parameter int LEN_ACTIVE   = DEF_H_ACTIVE,
    parameter int LEN_FRONT    = DEF_H_FRONT,
    parameter int LEN_SYNC     = DEF_H_SYNC,
    parameter int LEN_BACK     = DEF_H_BACK
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_advance,
    output phase_e                  o_phase,
    output logic [COUNTER_SIZE-1:0] o_position,
    output logic                    o_wrap
);

    localparam logic [COUNTER_SIZE-1:0] ZERO        = COUNTER_SIZE'(0);
    localparam logic [COUNTER_SIZE-1:0] ONE         = COUNTER_SIZE'(1);
    localparam logic [COUNTER_SIZE-1:0] LAST_ACTIVE = COUNTER_SIZE'(LEN_ACTIVE - 1);
    localparam logic [COUNTER_SIZE-1:0] LAST_FRONT  = COUNTER_SIZE'(LEN_FRONT - 1);
    localparam logic [COUNTER_SIZE-1:0] LAST_SYNC   = COUNTER_SIZE'(LEN_SYNC - 1);
    localparam logic [COUNTER_SIZE-1:0] LAST_BACK   = COUNTER_SIZE'(LEN_BACK - 1);

    phase_e                  r_phase;
    phase_e                  w_phase_nxt;
    logic [COUNTER_SIZE-1:0] r_count;
    logic [COUNTER_SIZE-1:0] w_count_nxt;
    logic [COUNTER_SIZE-1:0] r_position;
    logic [COUNTER_SIZE-1:0] w_position_nxt;
    logic [COUNTER_SIZE-1:0] w_last;
    logic                    w_wrap;

    // Terminal phase count for the phase currently being timed.
    always_comb begin
        case (r_phase)
            PHASE_ACTIVE: w_last = LAST_ACTIVE;
            PHASE_FRONT:  w_last = LAST_FRONT;
            PHASE_SYNC:   w_last = LAST_SYNC;
            PHASE_BACK:   w_last = LAST_BACK;
            default:      w_last = LAST_BACK;
        endcase
    end

    // Next phase, phase count and position; wrap flags BACK -> ACTIVE.
    always_comb begin
        w_phase_nxt    = r_phase;
        w_count_nxt    = r_count;
        w_position_nxt = r_position;
        w_wrap         = 1'b0;
        if (i_advance) begin
            if (r_count == w_last) begin
                w_count_nxt = ZERO;
                case (r_phase)
                    PHASE_ACTIVE: w_phase_nxt = PHASE_FRONT;
                    PHASE_FRONT:  w_phase_nxt = PHASE_SYNC;
                    PHASE_SYNC:   w_phase_nxt = PHASE_BACK;
                    PHASE_BACK:   w_phase_nxt = PHASE_ACTIVE;
                    default:      w_phase_nxt = PHASE_ACTIVE;
                endcase
                if (r_phase == PHASE_BACK) begin
                    w_position_nxt = ZERO;
                    w_wrap         = 1'b1;
                end else begin
                    w_position_nxt = r_position + ONE;
                end
            end else begin
                w_count_nxt    = r_count + ONE;
                w_position_nxt = r_position + ONE;
            end
        end else begin
            w_wrap = 1'b0;
        end
    end

    // Axis state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase    <= PHASE_ACTIVE;
            r_count    <= ZERO;
            r_position <= ZERO;
        end else begin
            r_phase    <= w_phase_nxt;
            r_count    <= w_count_nxt;
            r_position <= w_position_nxt;
        end
    end

    assign o_phase    = w_phase_nxt;
    assign o_position = w_position_nxt;
    assign o_wrap     = w_wrap;

endmodule

// File: rtl/vga_timing_sequencer.sv
// Raster timing generator: horizontal axis advances on every enabled
// clock, vertical axis advances on the horizontal wrap. The first
// enabled edge after reset presents position (0,0) without advancing,
// after which every enabled edge moves one pixel.
module vga_timing_sequencer
    import vga_timing_pkg::*;
#(
    parameter int   COUNTER_SIZE  = DEF_COUNTER_SIZE,
    parameter int   H_ACTIVE      = DEF_H_ACTIVE,
    parameter int   H_FRONT       = DEF_H_FRONT,
    parameter int   H_SYNC        = DEF_H_SYNC,
    parameter int   H_BACK        = DEF_H_BACK,
    parameter int   V_ACTIVE      = DEF_V_ACTIVE,
    parameter int   V_FRONT       = DEF_V_FRONT,
    parameter int   V_SYNC        = DEF_V_SYNC,
    parameter int   V_BACK        = DEF_V_BACK,
    parameter logic SYNC_POLARITY = 1'b0
) (
    input  logic                          control_clock,
    input  logic                          control_reset_n,
    vga_timing_sequencer_if.master        bus
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    if (H_ACTIVE <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0) begin : g_bad_h_phase
        $error("vga_timing_sequencer: horizontal phase length must be non-zero");
    end
    if (V_ACTIVE <= 0 || V_FRONT <= 0 || V_SYNC <= 0 || V_BACK <= 0) begin : g_bad_v_phase
        $error("vga_timing_sequencer: vertical phase length must be non-zero");
    end
    if (H_TOTAL > (2 ** COUNTER_SIZE) || V_TOTAL > (2 ** COUNTER_SIZE)) begin : g_bad_total
        $error("vga_timing_sequencer: total exceeds counter range");
    end

    phase_e                  w_h_phase;
    phase_e                  w_v_phase;
    logic [COUNTER_SIZE-1:0] w_h_position;
    logic [COUNTER_SIZE-1:0] w_v_position;
    logic                    w_h_wrap;
    logic                    w_v_wrap;
    logic                    w_first;
    logic                    w_run;

    logic                    r_started;
    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_display_enable;
    logic [COUNTER_SIZE-1:0] r_pixel_x;
    logic [COUNTER_SIZE-1:0] r_pixel_y;
    logic                    r_line_start;
    logic                    r_frame_start;

    // First enabled edge only latches (0,0); later enabled edges advance.
    assign w_first = bus.enable & ~r_started;
    assign w_run   = bus.enable & r_started;

    vga_axis_sequencer #(
        .COUNTER_SIZE (COUNTER_SIZE),
        .LEN_ACTIVE   (H_ACTIVE),
        .LEN_FRONT    (H_FRONT),
        .LEN_SYNC     (H_SYNC),
        .LEN_BACK     (H_BACK)
    ) u_h_axis (
        .i_clk      (control_clock),
        .i_rst_n    (control_reset_n),
        .i_advance  (w_run),
        .o_phase    (w_h_phase),
        .o_position (w_h_position),
        .o_wrap     (w_h_wrap)
    );

    vga_axis_sequencer #(
        .COUNTER_SIZE (COUNTER_SIZE),
        .LEN_ACTIVE   (V_ACTIVE),
        .LEN_FRONT    (V_FRONT),
        .LEN_SYNC     (V_SYNC),
        .LEN_BACK     (V_BACK)
    ) u_v_axis (
        .i_clk      (control_clock),
        .i_rst_n    (control_reset_n),
        .i_advance  (w_h_wrap),
        .o_phase    (w_v_phase),
        .o_position (w_v_position),
        .o_wrap     (w_v_wrap)
    );

    // Register outputs decoded from the values the axes load this edge.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_started        <= 1'b0;
            r_hsync          <= ~SYNC_POLARITY;
            r_vsync          <= ~SYNC_POLARITY;
            r_display_enable <= 1'b0;
            r_pixel_x        <= COUNTER_SIZE'(0);
            r_pixel_y        <= COUNTER_SIZE'(0);
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
        end else if (bus.enable) begin
            r_started        <= 1'b1;
            r_hsync          <= (w_h_phase == PHASE_SYNC) ? SYNC_POLARITY : ~SYNC_POLARITY;
            r_vsync          <= (w_v_phase == PHASE_SYNC) ? SYNC_POLARITY : ~SYNC_POLARITY;
            r_display_enable <= (w_h_phase == PHASE_ACTIVE) && (w_v_phase == PHASE_ACTIVE);
            r_pixel_x        <= w_h_position;
            r_pixel_y        <= w_v_position;
            r_line_start     <= w_first | w_h_wrap;
            r_frame_start    <= w_first | w_v_wrap;
        end else begin
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
        end
    end

    assign bus.hsync          = r_hsync;
    assign bus.vsync          = r_vsync;
    assign bus.display_enable = r_display_enable;
    assign bus.pixel_x        = r_pixel_x;
    assign bus.pixel_y        = r_pixel_y;
    assign bus.line_start     = r_line_start;
    assign bus.frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Self-checking bench: a default 1024x768 instance and a small
// 8/2/2/2 x 4/1/1/1 active-high-sync instance share clock, reset and
// enable. A coordinate-level model predicts every output each cycle.
module tb_vga_timing_sequencer;

    localparam int CS = 11;

    localparam int HA  [2] = '{1024, 8};
    localparam int HF  [2] = '{24, 2};
    localparam int HS  [2] = '{136, 2};
    localparam int HB  [2] = '{144, 2};
    localparam int VA  [2] = '{768, 4};
    localparam int VF  [2] = '{3, 1};
    localparam int VS  [2] = '{6, 1};
    localparam int VB  [2] = '{29, 1};
    localparam bit POL [2] = '{1'b0, 1'b1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    bit   chk_on = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_sequencer_if #(.COUNTER_SIZE(CS)) bus_b ();
    vga_timing_sequencer_if #(.COUNTER_SIZE(CS)) bus_s ();

    assign bus_b.enable = en;
    assign bus_s.enable = en;

    vga_timing_sequencer u_big (
        .control_clock   (clk),
        .control_reset_n (rst_n),
        .bus             (bus_b)
    );

    vga_timing_sequencer #(
        .COUNTER_SIZE (CS),
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .SYNC_POLARITY (1'b1)
    ) u_small (
        .control_clock   (clk),
        .control_reset_n (rst_n),
        .bus             (bus_s)
    );

    // ---------------- behavioural model (coordinates only) ----------------
    int m_x  [2];
    int m_y  [2];
    bit m_st [2];
    bit m_ls [2];
    bit m_fs [2];

    function automatic int ht(input int d);
        return HA[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int vt(input int d);
        return VA[d] + VF[d] + VS[d] + VB[d];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_x[d]  <= 0;
                m_y[d]  <= 0;
                m_st[d] <= 1'b0;
                m_ls[d] <= 1'b0;
                m_fs[d] <= 1'b0;
            end else if (en) begin
                m_st[d] <= 1'b1;
                m_x[d]  <= m_st[d] ? (m_x[d] + 1) % ht(d) : m_x[d];
                m_y[d]  <= (m_st[d] && m_x[d] == ht(d) - 1) ? (m_y[d] + 1) % vt(d) : m_y[d];
                m_ls[d] <= !m_st[d] || (m_x[d] == ht(d) - 1);
                m_fs[d] <= !m_st[d] || (m_x[d] == ht(d) - 1 && m_y[d] == vt(d) - 1);
            end else begin
                m_ls[d] <= 1'b0;
                m_fs[d] <= 1'b0;
            end
        end
    end

    // Expected {x, y, hsync, vsync, de, line_start, frame_start}.
    function automatic logic [26:0] exp_vec(input int d);
        logic [CS-1:0] ex;
        logic [CS-1:0] ey;
        logic hs;
        logic vs;
        logic de;
        ex = CS'(m_x[d]);
        ey = CS'(m_y[d]);
        hs = (m_x[d] >= HA[d] + HF[d] && m_x[d] < HA[d] + HF[d] + HS[d]) ? POL[d] : !POL[d];
        vs = (m_y[d] >= VA[d] + VF[d] && m_y[d] < VA[d] + VF[d] + VS[d]) ? POL[d] : !POL[d];
        de = m_st[d] && m_x[d] < HA[d] && m_y[d] < VA[d];
        return {ex, ey, hs, vs, de, m_ls[d], m_fs[d]};
    endfunction

    logic [26:0] dut_vec [2];
    assign dut_vec[0] = {bus_b.pixel_x, bus_b.pixel_y, bus_b.hsync, bus_b.vsync,
                         bus_b.display_enable, bus_b.line_start, bus_b.frame_start};
    assign dut_vec[1] = {bus_s.pixel_x, bus_s.pixel_y, bus_s.hsync, bus_s.vsync,
                         bus_s.display_enable, bus_s.line_start, bus_s.frame_start};

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                logic [26:0] e;
                logic [26:0] a;
                e = exp_vec(d);
                a = dut_vec[d];
                n_chk++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL model_cmp[%0d] t=%0t actual x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b required x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                             d, $time, a[26:16], a[15:5], a[4], a[3], a[2], a[1], a[0],
                             e[26:16], e[15:5], e[4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic goto_x(input int target);
        int k;
        k = 0;
        while (int'(bus_b.pixel_x) != target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("reach_x_%0d", target), int'(bus_b.pixel_x), target);
    endtask

    initial begin
        int de_cnt;
        int hs_cnt;
        int ls_cnt;
        int hs_min;
        int hs_max;
        int fs_cnt;
        int vs_cnt;
        int bad;

        repeat (3) @(negedge clk);
        chk_on = 1'b1;

        // Reset state.
        chk("rst_x", int'(bus_b.pixel_x), 0);
        chk("rst_hsync", int'(bus_b.hsync), 1);
        chk("rst_de", int'(bus_b.display_enable), 0);
        chk("rst_fs", int'(bus_b.frame_start), 0);
        chk("rst_small_hsync", int'(bus_s.hsync), 0);

        // First enabled edge shows (0,0).
        #2 rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);
        chk("first_x", int'(bus_b.pixel_x), 0);
        chk("first_y", int'(bus_b.pixel_y), 0);
        chk("first_de", int'(bus_b.display_enable), 1);
        chk("first_fs", int'(bus_b.frame_start), 1);
        chk("first_ls", int'(bus_b.line_start), 1);
        chk("first_hsync", int'(bus_b.hsync), 1);
        chk("first_vsync", int'(bus_b.vsync), 1);

        // One full line on the default timing.
        de_cnt = 0; hs_cnt = 0; ls_cnt = 0; hs_min = 9999; hs_max = -1;
        for (int i = 0; i < 1328; i++) begin
            @(negedge clk);
            if (bus_b.display_enable) de_cnt++;
            if (bus_b.line_start) ls_cnt++;
            if (!bus_b.hsync) begin
                hs_cnt++;
                if (int'(bus_b.pixel_x) < hs_min) hs_min = int'(bus_b.pixel_x);
                if (int'(bus_b.pixel_x) > hs_max) hs_max = int'(bus_b.pixel_x);
            end
        end
        chk("line_de_count", de_cnt, 1024);
        chk("line_hsync_count", hs_cnt, 136);
        chk("line_hsync_first_x", hs_min, 1048);
        chk("line_hsync_last_x", hs_max, 1183);
        chk("line_ls_count", ls_cnt, 1);
        chk("line_wrap_x", int'(bus_b.pixel_x), 0);
        chk("line_wrap_y", int'(bus_b.pixel_y), 1);
        chk("line_wrap_ls", int'(bus_b.line_start), 1);

        // Three small frames: 14 x 7 = 98 clocks each.
        fs_cnt = 0; vs_cnt = 0; de_cnt = 0;
        for (int i = 0; i < 294; i++) begin
            @(negedge clk);
            if (bus_s.frame_start) fs_cnt++;
            if (bus_s.vsync) vs_cnt++;
            if (bus_s.display_enable) de_cnt++;
        end
        chk("small_fs_count", fs_cnt, 3);
        chk("small_vsync_count", vs_cnt, 42);
        chk("small_de_count", de_cnt, 96);

        // Freeze at x=500 for 50 cycles.
        goto_x(500);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (int'(bus_b.pixel_x) != 500 || bus_b.line_start || bus_b.frame_start) bad++;
        end
        chk("freeze_hold", bad, 0);
        en = 1'b1;
        @(negedge clk);
        chk("resume_x", int'(bus_b.pixel_x), 501);

        // Reset inside hsync.
        goto_x(1100);
        chk("pre_reset_hsync", int'(bus_b.hsync), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hsync", int'(bus_b.hsync), 1);
        chk("midrst_x", int'(bus_b.pixel_x), 0);
        chk("midrst_de", int'(bus_b.display_enable), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("restart_x", int'(bus_b.pixel_x), 0);
        chk("restart_fs", int'(bus_b.frame_start), 1);
        chk("restart_de", int'(bus_b.display_enable), 1);

        // Randomized enable with occasional resets; model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #2;
            en = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
